// File: rtl/channel_acq_controller_multi_pkg.sv
// Shared state encoding and FIFO word layout for the async acquisition controller.
// FIFO word = {timed_out, missing_mask, trig_type, trig_num}, num in the LSBs.
package channel_acq_controller_multi_pkg;

   localparam int IDLE    = 0;
   localparam int WAIT    = 1;
   localparam int STORE   = 2;
   localparam int READOUT = 3;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'(1 << IDLE),
      ST_WAIT    = 4'(1 << WAIT),
      ST_STORE   = 4'(1 << STORE),
      ST_READOUT = 4'(1 << READOUT)
   } acq_state_t;

   function automatic int fifo_num_lsb();
      return 0;
   endfunction

   function automatic int fifo_type_lsb(input int num_w);
      return num_w;
   endfunction

   function automatic int fifo_mask_lsb(input int type_w, input int num_w);
      return type_w + num_w;
   endfunction

   function automatic int fifo_tmo_bit(input int n_chan, input int type_w, input int num_w);
      return n_chan + type_w + num_w;
   endfunction

   function automatic int fifo_word_w(input int n_chan, input int type_w, input int num_w);
      return 1 + n_chan + type_w + num_w;
   endfunction

endpackage

// File: rtl/channel_acq_controller_multi_if.sv
// Trigger, channel and event-FIFO signals of the acquisition controller.
// slave = controller side, master = TTC/channel/FIFO environment side.
interface channel_acq_controller_multi_if
   import channel_acq_controller_multi_pkg::*;
#(
   parameter int N_CHAN      = 5,
   parameter int TRIG_TYPE_W = 5,
   parameter int TRIG_NUM_W  = 24
);
   localparam int FIFO_W = fifo_word_w(N_CHAN, TRIG_TYPE_W, TRIG_NUM_W);

   logic                   ttc_trigger;
   logic [TRIG_TYPE_W-1:0] ttc_trig_type;
   logic [TRIG_NUM_W-1:0]  ttc_trig_num;
   logic                   ttc_acq_ready;
   logic                   pulse_trigger;
   logic [N_CHAN-1:0]      acq_dones;
   logic [2*N_CHAN-1:0]    acq_enable;
   logic [N_CHAN-1:0]      acq_trig;
   logic                   fifo_ready;
   logic                   fifo_valid;
   logic [FIFO_W-1:0]      fifo_data;

   modport master (
      output ttc_trigger, ttc_trig_type, ttc_trig_num, pulse_trigger, acq_dones, fifo_ready,
      input  ttc_acq_ready, acq_enable, acq_trig, fifo_valid, fifo_data
   );

   modport slave (
      input  ttc_trigger, ttc_trig_type, ttc_trig_num, pulse_trigger, acq_dones, fifo_ready,
      output ttc_acq_ready, acq_enable, acq_trig, fifo_valid, fifo_data
   );

endinterface

// File: rtl/channel_acq_controller_multi_pulse_holdoff_counter.sv
// Pulse-trigger dead-time counter: load on a forwarded pulse, count down to zero.
// zero is valid the cycle after the load settles; no backpressure.
module pulse_holdoff_counter #(
   parameter int TMO_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [TMO_W-1:0] load_val,
   output logic             zero
);
   logic [TMO_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - TMO_W'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/channel_acq_controller_multi.sv
// Async-mode acquisition controller: TTC trigger -> wait for channel dones -> one FIFO word -> readout.
// FIFO word is registered and held until fifo_ready; TTC triggers outside IDLE are dropped and counted.
module channel_acq_controller_multi
   import channel_acq_controller_multi_pkg::*;
#(
   parameter int N_CHAN      = 5,
   parameter int TRIG_TYPE_W = 5,
   parameter int TRIG_NUM_W  = 24,
   parameter int TMO_W       = 16,
   parameter int DROP_W      = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_CHAN-1:0]      chan_en,
   input  logic                   accept_pulse_triggers,
   input  logic                   async_mode,
   input  logic [TMO_W-1:0]       timeout_cycles,
   input  logic [TMO_W-1:0]       holdoff_cycles,
   input  logic                   readout_done,
   channel_acq_controller_multi_if.slave bus,
   output logic [DROP_W-1:0]      drop_count,
   output logic [3:0]             state
);
   localparam int FIFO_W   = fifo_word_w(N_CHAN, TRIG_TYPE_W, TRIG_NUM_W);
   localparam int NUM_LSB  = fifo_num_lsb();
   localparam int TYPE_LSB = fifo_type_lsb(TRIG_NUM_W);
   localparam int MASK_LSB = fifo_mask_lsb(TRIG_TYPE_W, TRIG_NUM_W);
   localparam int TMO_BIT  = fifo_tmo_bit(N_CHAN, TRIG_TYPE_W, TRIG_NUM_W);

   acq_state_t             st;
   logic [N_CHAN-1:0]      done_mask;
   logic [TMO_W-1:0]       tmo_cnt;
   logic [TRIG_TYPE_W-1:0] type_q;
   logic [TRIG_NUM_W-1:0]  num_q;
   logic                   ttc_go, pulse_path, pulse_fwd, hold_zero, all_done, tmo_hit;
   logic [FIFO_W-1:0]      word;

   assign state              = st;
   assign bus.ttc_acq_ready  = state[IDLE];
   assign ttc_go             = bus.ttc_trigger & async_mode;

   // TTC wins over a same-cycle front-panel pulse
   assign pulse_path     = state[IDLE] & ~ttc_go & accept_pulse_triggers & async_mode;
   assign pulse_fwd      = pulse_path & bus.pulse_trigger & hold_zero;
   assign bus.acq_enable = pulse_path ? '1 : '0;
   assign bus.acq_trig   = pulse_fwd ? chan_en : '0;

   pulse_holdoff_counter #(.TMO_W(TMO_W)) u_holdoff (
      .clk      (clk),
      .reset    (reset),
      .load     (pulse_fwd),
      .load_val (holdoff_cycles),
      .zero     (hold_zero)
   );

   assign all_done = ((done_mask & chan_en) == chan_en);
   assign tmo_hit  = (timeout_cycles != '0) && (tmo_cnt == timeout_cycles - TMO_W'(1));

   always_comb begin
      word                          = '0;
      word[NUM_LSB +: TRIG_NUM_W]   = num_q;
      word[TYPE_LSB +: TRIG_TYPE_W] = type_q;
      word[MASK_LSB +: N_CHAN]      = chan_en & ~done_mask;
      word[TMO_BIT]                 = ~all_done;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st             <= ST_IDLE;
         done_mask      <= '0;
         tmo_cnt        <= '0;
         type_q         <= '0;
         num_q          <= '0;
         bus.fifo_valid <= 1'b0;
         bus.fifo_data  <= '0;
         drop_count     <= '0;
      end else begin
         if (ttc_go && !state[IDLE] && drop_count != '1)
            drop_count <= drop_count + DROP_W'(1);

         case (st)
            ST_IDLE: begin
               if (ttc_go) begin
                  type_q    <= bus.ttc_trig_type;
                  num_q     <= bus.ttc_trig_num;
                  done_mask <= '0;
                  tmo_cnt   <= '0;
                  st        <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               done_mask <= done_mask | bus.acq_dones;
               tmo_cnt   <= tmo_cnt + TMO_W'(1);
               // completion is judged on the registered mask, so it beats a same-cycle timeout
               if (all_done || tmo_hit) begin
                  bus.fifo_data  <= word;
                  bus.fifo_valid <= 1'b1;
                  st             <= ST_STORE;
               end
            end
            ST_STORE: begin
               if (bus.fifo_ready) begin
                  bus.fifo_valid <= 1'b0;
                  st             <= ST_READOUT;
               end
            end
            ST_READOUT: begin
               if (readout_done)
                  st <= ST_IDLE;
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_channel_acq_controller_multi.sv
// Directed bench for channel_acq_controller_multi: FIFO words checked by a scoreboard monitor,
// state/trigger/counter outputs checked inline at the falling edge.
module tb_channel_acq_controller_multi;
   localparam int N_CHAN = 5, TT_W = 5, TN_W = 24, TMO_W = 16, DROP_W = 4;
   localparam int FW = 1 + N_CHAN + TT_W + TN_W;

   logic              clk = 1'b0;
   logic              reset;
   logic [N_CHAN-1:0] chan_en;
   logic              accept_pulse_triggers, async_mode, readout_done;
   logic [TMO_W-1:0]  timeout_cycles, holdoff_cycles;
   logic [DROP_W-1:0] drop_count;
   logic [3:0]        state;

   channel_acq_controller_multi_if #(.N_CHAN(N_CHAN), .TRIG_TYPE_W(TT_W), .TRIG_NUM_W(TN_W)) bus ();

   channel_acq_controller_multi #(
      .N_CHAN(N_CHAN), .TRIG_TYPE_W(TT_W), .TRIG_NUM_W(TN_W), .TMO_W(TMO_W), .DROP_W(DROP_W)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .chan_en               (chan_en),
      .accept_pulse_triggers (accept_pulse_triggers),
      .async_mode            (async_mode),
      .timeout_cycles        (timeout_cycles),
      .holdoff_cycles        (holdoff_cycles),
      .readout_done          (readout_done),
      .bus                   (bus),
      .drop_count            (drop_count),
      .state                 (state)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [FW-1:0] exp_q[$];
   logic [FW-1:0] exp_w;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // scoreboard monitor: every accepted FIFO word must match the oldest expected one
   always @(negedge clk) begin
      if (!reset && bus.fifo_valid && bus.fifo_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL fifo_word unexpected actual=%0h required=none", bus.fifo_data);
         end else begin
            exp_w = exp_q.pop_front();
            chk("fifo_word", 64'(bus.fifo_data), 64'(exp_w));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; chan_en = '0; accept_pulse_triggers = 1'b0; async_mode = 1'b0;
      timeout_cycles = '0; holdoff_cycles = '0; readout_done = 1'b0;
      bus.ttc_trigger = 1'b0; bus.ttc_trig_type = '0; bus.ttc_trig_num = '0;
      bus.pulse_trigger = 1'b0; bus.acq_dones = '0; bus.fifo_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
      settle();
      chk("rst_state", 64'(state), 64'h1);
      chk("rst_valid", 64'(bus.fifo_valid), 64'h0);
      chk("rst_drop", 64'(drop_count), 64'h0);
      chk("rst_ready", 64'(bus.ttc_acq_ready), 64'h1);
      chk("rst_enable", 64'(bus.acq_enable), 64'h0);
      chk("rst_data", 64'(bus.fifo_data), 64'h0);

      // 1: staggered dones, all enabled channels complete
      tick();
      async_mode = 1'b1; chan_en = 5'b10101;
      bus.ttc_trigger = 1'b1; bus.ttc_trig_type = 5'h02; bus.ttc_trig_num = 24'h000123;
      exp_q.push_back({1'b0, 5'b00000, 5'h02, 24'h000123});
      tick();
      bus.ttc_trigger = 1'b0; bus.acq_dones = 5'b00001;
      settle(); chk("t1_wait", 64'(state), 64'h2);
      chk("t1_not_ready", 64'(bus.ttc_acq_ready), 64'h0);
      tick(); bus.acq_dones = '0;
      tick(); tick();
      bus.acq_dones = 5'b10100;
      tick(); bus.acq_dones = '0;
      settle(); chk("t1_still_wait", 64'(state), 64'h2);
      tick();
      settle(); chk("t1_store", 64'(state), 64'h4);
      chk("t1_valid", 64'(bus.fifo_valid), 64'h1);
      tick();
      settle(); chk("t1_readout", 64'(state), 64'h8);
      chk("t1_valid_drop", 64'(bus.fifo_valid), 64'h0);
      readout_done = 1'b1; tick(); readout_done = 1'b0;
      settle(); chk("t1_idle", 64'(state), 64'h1);

      // 2: timeout with channel 3 missing
      tick();
      chan_en = 5'b11111; timeout_cycles = 16'd100;
      bus.ttc_trigger = 1'b1; bus.ttc_trig_type = 5'h1F; bus.ttc_trig_num = 24'hABCDEF;
      exp_q.push_back({1'b1, 5'b01000, 5'h1F, 24'hABCDEF});
      tick();
      bus.ttc_trigger = 1'b0; bus.acq_dones = 5'b10111;
      tick(); bus.acq_dones = '0;
      repeat (98) tick();
      settle(); chk("t2_wait_99", 64'(state), 64'h2);
      tick();
      settle(); chk("t2_store_100", 64'(state), 64'h4);
      tick();
      readout_done = 1'b1; tick(); readout_done = 1'b0;
      settle(); chk("t2_idle", 64'(state), 64'h1);
      timeout_cycles = '0;

      // 3: pulse pass-through with holdoff 4
      tick();
      chan_en = 5'b10101; accept_pulse_triggers = 1'b1; holdoff_cycles = 16'd4;
      for (int i = 0; i < 10; i++) begin
         bus.pulse_trigger = 1'b1;
         settle();
         chk($sformatf("t3_trig_%0d", i), 64'(bus.acq_trig), (i == 0 || i == 5) ? 64'h15 : 64'h0);
         if (i == 0) chk("t3_enable", 64'(bus.acq_enable), 64'h3FF);
         tick();
      end
      bus.pulse_trigger = 1'b0;
      repeat (6) tick();

      // 6: TTC and pulse in the same IDLE cycle
      bus.ttc_trigger = 1'b1; bus.pulse_trigger = 1'b1;
      bus.ttc_trig_type = 5'h07; bus.ttc_trig_num = 24'h000777;
      exp_q.push_back({1'b0, 5'b00000, 5'h07, 24'h000777});
      settle();
      chk("t6_trig", 64'(bus.acq_trig), 64'h0);
      chk("t6_enable", 64'(bus.acq_enable), 64'h0);
      tick();
      bus.ttc_trigger = 1'b0; bus.pulse_trigger = 1'b0; bus.acq_dones = 5'b11111;
      settle(); chk("t6_wait", 64'(state), 64'h2);
      tick(); bus.acq_dones = '0;
      tick();
      settle(); chk("t6_store", 64'(state), 64'h4);
      tick();
      readout_done = 1'b1; tick(); readout_done = 1'b0;
      accept_pulse_triggers = 1'b0;

      // 4: backpressure, dropped triggers, drop counter saturation
      chan_en = 5'b00001; bus.fifo_ready = 1'b0;
      bus.ttc_trigger = 1'b1; bus.ttc_trig_type = 5'h03; bus.ttc_trig_num = 24'h000456;
      exp_q.push_back({1'b0, 5'b00000, 5'h03, 24'h000456});
      tick();
      bus.acq_dones = 5'b00001;
      tick();
      bus.acq_dones = '0;
      tick();
      settle(); chk("t4_store", 64'(state), 64'h4);
      tick();
      bus.ttc_trigger = 1'b0;
      for (int i = 0; i < 10; i++) begin
         settle();
         chk("t4_hold_valid", 64'(bus.fifo_valid), 64'h1);
         chk("t4_hold_data", 64'(bus.fifo_data), 64'({1'b0, 5'b00000, 5'h03, 24'h000456}));
         tick();
      end
      bus.fifo_ready = 1'b1;
      tick();
      settle(); chk("t4_readout", 64'(state), 64'h8);
      chk("t4_drop3", 64'(drop_count), 64'h3);
      bus.ttc_trigger = 1'b1;
      repeat (12) tick();
      settle(); chk("t4_drop_full", 64'(drop_count), 64'hF);
      repeat (8) tick();
      settle(); chk("t4_drop_sat", 64'(drop_count), 64'hF);
      bus.ttc_trigger = 1'b0;
      readout_done = 1'b1; tick(); readout_done = 1'b0;
      settle(); chk("t4_idle", 64'(state), 64'h1);

      // 5: reset in WAIT, then in STORE
      tick();
      chan_en = 5'b11111; bus.ttc_trigger = 1'b1;
      tick();
      bus.ttc_trigger = 1'b0;
      settle(); chk("t5_wait", 64'(state), 64'h2);
      reset = 1'b1; tick(); reset = 1'b0;
      settle();
      chk("t5w_state", 64'(state), 64'h1);
      chk("t5w_valid", 64'(bus.fifo_valid), 64'h0);
      chk("t5w_drop", 64'(drop_count), 64'h0);
      chk("t5w_ready", 64'(bus.ttc_acq_ready), 64'h1);
      tick();
      chan_en = '0; bus.fifo_ready = 1'b0; bus.ttc_trigger = 1'b1;
      tick();
      bus.ttc_trigger = 1'b0;
      tick();
      settle(); chk("t5_store_chan0", 64'(state), 64'h4);
      chk("t5_store_valid", 64'(bus.fifo_valid), 64'h1);
      bus.ttc_trigger = 1'b1; tick(); bus.ttc_trigger = 1'b0;
      settle(); chk("t5_drop1", 64'(drop_count), 64'h1);
      reset = 1'b1; tick(); reset = 1'b0;
      settle();
      chk("t5s_state", 64'(state), 64'h1);
      chk("t5s_valid", 64'(bus.fifo_valid), 64'h0);
      chk("t5s_drop", 64'(drop_count), 64'h0);
      chk("t5s_ready", 64'(bus.ttc_acq_ready), 64'h1);
      bus.fifo_ready = 1'b1;

      repeat (3) tick();
      chk("sb_empty", 64'(exp_q.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
